// File: rtl/battle_pkg.sv
// Shared Battleship definitions.
//   - Turn codes driven to GridEngine on `turn`.
//   - Cell-status codes stored by GridEngine.
//   - Game-phase state enum owned by game_turn_scheduler.
//   - turn_of(): maps a game phase to the turn code GridEngine consumes.
package battle_pkg;

  localparam logic [1:0] TURN_IA_PLACING     = 2'd0;
  localparam logic [1:0] TURN_PLAYER_PLACING = 2'd1;
  localparam logic [1:0] TURN_PLAYER_SHOOT   = 2'd2;
  localparam logic [1:0] TURN_IA_SHOOT       = 2'd3;

  localparam logic [2:0] CELL_FREE       = 3'd0;
  localparam logic [2:0] CELL_OCCUPIED   = 3'd1;
  localparam logic [2:0] CELL_PLAYER_HIT = 3'd2;
  localparam logic [2:0] CELL_IA_HIT     = 3'd3;
  localparam logic [2:0] CELL_BOTH_HIT   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_IA_PLACE     = 3'd1,
    ST_PLAYER_PLACE = 3'd2,
    ST_PLAYER_SHOOT = 3'd3,
    ST_IA_SHOOT     = 3'd4,
    ST_GAME_OVER    = 3'd5
  } state_e;

  // IDLE and GAME_OVER report code 0; `active` low marks it as meaningless.
  function automatic logic [1:0] turn_of(state_e s);
    case (s)
      ST_PLAYER_PLACE: turn_of = TURN_PLAYER_PLACING;
      ST_PLAYER_SHOOT: turn_of = TURN_PLAYER_SHOOT;
      ST_IA_SHOOT:     turn_of = TURN_IA_SHOOT;
      default:         turn_of = TURN_IA_PLACING;
    endcase
  endfunction

endpackage

// File: rtl/turn_timeout_timer.sv
// Player shoot-turn watchdog.
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset
//   clear          : forces the count back to zero (takes priority)
//   enable         : count one per cycle while high
//   expired        : high while enabled and the count is TIMEOUT_CYCLES-1
module turn_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] r_count;

  assign expired = enable && (r_count == W'(TIMEOUT_CYCLES - 1));

  // Holds at the terminal value; the scheduler leaves the state on expiry.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/game_turn_scheduler.sv
// Battleship game-phase sequencer in front of GridEngine.
// Steps IA then player through ship placement, alternates shooting turns
// (a hit grants another shot) and detects the winner.
// Ports:
//   clk_in, rst_in          : clock, synchronous active-high reset
//   start                   : pulse, begins a game from IDLE or GAME_OVER
//   place_done / place_ok   : placement attempt finished / accepted
//   shot_done / shot_hit    : shot resolved / it hit a ship
//   turn                    : 0 IA place, 1 player place, 2 player shoot, 3 IA shoot
//   active                  : high outside IDLE and GAME_OVER
//   ship_index / ship_size  : ship being placed and its length (size is combinational)
//   player_hits / ia_hits   : hit counters
//   game_over / winner      : game finished / 0 player, 1 IA
//   dbg_state               : current FSM state (battle_pkg::state_e encoding)
// Handshake: all inputs are single-cycle pulses sampled on the rising edge;
// a level held N cycles counts as N events. Every registered output updates
// on the edge that samples the pulse.
// Optional feature: define TURN_TIMEOUT_EN to bound the player shoot turn
// to TIMEOUT_CYCLES cycles; without it the player turn is unbounded.
module game_turn_scheduler
  import battle_pkg::*;
#(
  parameter int NUM_SHIPS      = 5,
  parameter int SHIP_SIZE0     = 2,
  parameter int SHIP_SIZE1     = 3,
  parameter int SHIP_SIZE2     = 3,
  parameter int SHIP_SIZE3     = 4,
  parameter int SHIP_SIZE4     = 5,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start,
  input  logic       place_done,
  input  logic       place_ok,
  input  logic       shot_done,
  input  logic       shot_hit,
  output logic [1:0] turn,
  output logic       active,
  output logic [2:0] ship_index,
  output logic [3:0] ship_size,
  output logic [4:0] player_hits,
  output logic [4:0] ia_hits,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] dbg_state
);

  localparam int TOTAL_CELLS = (NUM_SHIPS > 0 ? SHIP_SIZE0 : 0) + (NUM_SHIPS > 1 ? SHIP_SIZE1 : 0)
                             + (NUM_SHIPS > 2 ? SHIP_SIZE2 : 0) + (NUM_SHIPS > 3 ? SHIP_SIZE3 : 0)
                             + (NUM_SHIPS > 4 ? SHIP_SIZE4 : 0);
  localparam logic [4:0] TOTAL5    = 5'(TOTAL_CELLS);
  localparam logic [2:0] LAST_SHIP = 3'(NUM_SHIPS - 1);

  if (TOTAL_CELLS > 31 || TOTAL_CELLS < 1 || NUM_SHIPS < 1 || NUM_SHIPS > 5) begin : g_bad_cfg
    $error("game_turn_scheduler: need 1..5 ships and 1..31 total cells");
  end

  state_e     r_state, w_state_next;
  logic [2:0] r_ship_index, w_ship_index_next;
  logic [4:0] r_player_hits, w_player_hits_next;
  logic [4:0] r_ia_hits, w_ia_hits_next;
  logic       r_winner, w_winner_next;
  logic [1:0] r_turn;
  logic       r_active;
  logic       r_game_over;
  logic [4:0] w_player_inc, w_ia_inc;
  logic       w_timeout;

  assign w_player_inc = r_player_hits + 5'd1;
  assign w_ia_inc     = r_ia_hits + 5'd1;

`ifdef TURN_TIMEOUT_EN
  logic w_in_player_shoot;
  assign w_in_player_shoot = (r_state == ST_PLAYER_SHOOT);

  // Clearing whenever outside PLAYER_SHOOT makes every entry start at zero.
  turn_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (!w_in_player_shoot || shot_done),
    .enable (w_in_player_shoot),
    .expired(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next       = r_state;
    w_ship_index_next  = r_ship_index;
    w_player_hits_next = r_player_hits;
    w_ia_hits_next     = r_ia_hits;
    w_winner_next      = r_winner;
    case (r_state)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          w_state_next       = ST_IA_PLACE;
          w_ship_index_next  = 3'd0;
          w_player_hits_next = 5'd0;
          w_ia_hits_next     = 5'd0;
          w_winner_next      = 1'b0;
        end
      end
      ST_IA_PLACE, ST_PLAYER_PLACE: begin
        // A rejected attempt leaves ship_index alone so the same ship is retried.
        if (place_done && place_ok) begin
          if (r_ship_index == LAST_SHIP) begin
            w_state_next      = (r_state == ST_IA_PLACE) ? ST_PLAYER_PLACE : ST_PLAYER_SHOOT;
            w_ship_index_next = 3'd0;
          end else begin
            w_ship_index_next = r_ship_index + 3'd1;
          end
        end
      end
      ST_PLAYER_SHOOT: begin
        // A shot in the expiry cycle wins over the timeout.
        if (shot_done) begin
          if (shot_hit) begin
            w_player_hits_next = w_player_inc;
            if (w_player_inc == TOTAL5) begin
              w_state_next  = ST_GAME_OVER;
              w_winner_next = 1'b0;
            end
          end else begin
            w_state_next = ST_IA_SHOOT;
          end
        end else if (w_timeout) begin
          w_state_next = ST_IA_SHOOT;
        end
      end
      ST_IA_SHOOT: begin
        if (shot_done) begin
          if (shot_hit) begin
            w_ia_hits_next = w_ia_inc;
            if (w_ia_inc == TOTAL5) begin
              w_state_next  = ST_GAME_OVER;
              w_winner_next = 1'b1;
            end
          end else begin
            w_state_next = ST_PLAYER_SHOOT;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Phase-derived outputs are decoded from the next state so they are
  // registered alongside it rather than decoded after the flop.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= ST_IDLE;
      r_ship_index  <= 3'd0;
      r_player_hits <= 5'd0;
      r_ia_hits     <= 5'd0;
      r_winner      <= 1'b0;
      r_turn        <= TURN_IA_PLACING;
      r_active      <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_ship_index  <= w_ship_index_next;
      r_player_hits <= w_player_hits_next;
      r_ia_hits     <= w_ia_hits_next;
      r_winner      <= w_winner_next;
      r_turn        <= turn_of(w_state_next);
      r_active      <= (w_state_next != ST_IDLE) && (w_state_next != ST_GAME_OVER);
      r_game_over   <= (w_state_next == ST_GAME_OVER);
    end
  end

  always_comb begin
    ship_size = 4'd0;
    case (r_ship_index)
      3'd0:    ship_size = 4'(SHIP_SIZE0);
      3'd1:    ship_size = 4'(SHIP_SIZE1);
      3'd2:    ship_size = 4'(SHIP_SIZE2);
      3'd3:    ship_size = 4'(SHIP_SIZE3);
      3'd4:    ship_size = 4'(SHIP_SIZE4);
      default: ship_size = 4'd0;
    endcase
  end

  assign turn        = r_turn;
  assign active      = r_active;
  assign ship_index  = r_ship_index;
  assign player_hits = r_player_hits;
  assign ia_hits     = r_ia_hits;
  assign game_over   = r_game_over;
  assign winner      = r_winner;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_game_turn_scheduler.sv
module tb_game_turn_scheduler;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       start = 1'b0, place_done = 1'b0, place_ok = 1'b0;
  logic       shot_done = 1'b0, shot_hit = 1'b0;
  logic [1:0] turn;
  logic       active, game_over, winner;
  logic [2:0] ship_index, dbg_state;
  logic [3:0] ship_size;
  logic [4:0] player_hits, ia_hits;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic st, pd, pok, sd, sh;
    logic [1:0] turn;
    logic act;
    logic [2:0] idx;
    logic [3:0] sz;
    logic [4:0] ph, ih;
    logic go, win;
  } vec_t;

  vec_t tbl[$];

  game_turn_scheduler #(.TIMEOUT_CYCLES(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start),
    .place_done(place_done), .place_ok(place_ok),
    .shot_done(shot_done), .shot_hit(shot_hit),
    .turn(turn), .active(active), .ship_index(ship_index), .ship_size(ship_size),
    .player_hits(player_hits), .ia_hits(ia_hits), .game_over(game_over),
    .winner(winner), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  function automatic vec_t mk(logic st, logic pd, logic pok, logic sd, logic sh,
                              logic [1:0] t, logic a, logic [2:0] i, logic [3:0] s,
                              logic [4:0] ph, logic [4:0] ih, logic go, logic w);
    vec_t v;
    v.st = st; v.pd = pd; v.pok = pok; v.sd = sd; v.sh = sh;
    v.turn = t; v.act = a; v.idx = i; v.sz = s; v.ph = ph; v.ih = ih; v.go = go; v.win = w;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard compare of every output
  task automatic chk_all(input string tag, input int t, input int a, input int i, input int s,
                         input int ph, input int ih, input int go, input int w);
    chk({tag, ".turn"}, int'(turn), t);
    chk({tag, ".active"}, int'(active), a);
    chk({tag, ".ship_index"}, int'(ship_index), i);
    chk({tag, ".ship_size"}, int'(ship_size), s);
    chk({tag, ".player_hits"}, int'(player_hits), ph);
    chk({tag, ".ia_hits"}, int'(ia_hits), ih);
    chk({tag, ".game_over"}, int'(game_over), go);
    if (go != 0) chk({tag, ".winner"}, int'(winner), w);
  endtask

  // driver: hold pulses for exactly one rising edge, sample #1 after it
  task automatic cycle(input logic st, input logic pd, input logic pok, input logic sd, input logic sh);
    start = st; place_done = pd; place_ok = pok; shot_done = sd; shot_hit = sh;
    @(posedge clk_in);
    #1;
    start = 1'b0; place_done = 1'b0; place_ok = 1'b0; shot_done = 1'b0; shot_hit = 1'b0;
  endtask

  task automatic place_all_ships();
    for (int k = 0; k < 10; k++) cycle(0, 1, 1, 0, 0);
    chk("placed.turn", int'(turn), 2);
    chk("placed.ship_index", int'(ship_index), 0);
  endtask

  initial begin
    // sequence through both placement phases and into shooting
    tbl.push_back(mk(1,0,0,0,0, 0,1,0,2, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 0,1,1,3, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 0,1,2,3, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,1,2,3, 0,0,0,0)); // rejected: retry ship 2
    tbl.push_back(mk(0,0,0,0,0, 0,1,2,3, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1, 0,1,2,3, 0,0,0,0)); // shot ignored while placing
    tbl.push_back(mk(1,0,0,0,0, 0,1,2,3, 0,0,0,0)); // start ignored while active
    tbl.push_back(mk(0,1,1,0,0, 0,1,3,4, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 0,1,4,5, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 1,1,0,2, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 1,1,1,3, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 1,1,2,3, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 1,1,2,3, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 1,1,3,4, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 1,1,4,5, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 2,1,0,2, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 2,1,0,2, 0,0,0,0)); // placement ignored while shooting
    tbl.push_back(mk(0,0,0,1,1, 2,1,0,2, 1,0,0,0)); // hit: shoot again
    tbl.push_back(mk(0,0,0,1,0, 3,1,0,2, 1,0,0,0)); // miss: IA turn
    tbl.push_back(mk(0,0,0,1,1, 3,1,0,2, 1,1,0,0));
    tbl.push_back(mk(1,0,0,0,0, 3,1,0,2, 1,1,0,0));
    tbl.push_back(mk(0,0,0,1,0, 2,1,0,2, 1,1,0,0)); // IA miss: player turn
    tbl.push_back(mk(0,1,1,1,1, 2,1,0,2, 2,1,0,0)); // only the shot acts

    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    chk_all("reset", 0, 0, 0, 2, 0, 0, 0, 0);
    chk("reset.winner", int'(winner), 0);
    chk("reset.state", int'(dbg_state), 0);

    for (int v = 0; v < tbl.size(); v++) begin
      cycle(tbl[v].st, tbl[v].pd, tbl[v].pok, tbl[v].sd, tbl[v].sh);
      chk_all($sformatf("vec%0d", v), tbl[v].turn, tbl[v].act, tbl[v].idx, tbl[v].sz,
              tbl[v].ph, tbl[v].ih, tbl[v].go, tbl[v].win);
    end

    // player runs to 17 hits
    for (int k = 3; k <= 17; k++) begin
      cycle(0, 0, 0, 1, 1);
      if (k == 17) chk_all("pwin", 0, 0, 0, 2, 17, 1, 1, 0);
      else chk_all($sformatf("phit%0d", k), 2, 1, 0, 2, k, 1, 0, 0);
    end
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 1, 0, 0);
    chk_all("go_hold", 0, 0, 0, 2, 17, 1, 1, 0);
    cycle(1, 0, 0, 0, 0);
    chk_all("restart", 0, 1, 0, 2, 0, 0, 0, 0);

    // IA reaches 9 hits then mid-game reset
    place_all_ships();
    cycle(0, 0, 0, 1, 0);
    for (int k = 1; k <= 9; k++) cycle(0, 0, 0, 1, 1);
    chk_all("ia9", 3, 1, 0, 2, 0, 9, 0, 0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk_all("midrst", 0, 0, 0, 2, 0, 0, 0, 0);
    chk("midrst.winner", int'(winner), 0);
    chk("midrst.state", int'(dbg_state), 0);
    rst_in = 1'b0;
    cycle(0, 0, 0, 1, 1);
    chk_all("idle_ignore", 0, 0, 0, 2, 0, 0, 0, 0);

    // IA wins
    cycle(1, 0, 0, 0, 0);
    place_all_ships();
    cycle(0, 0, 0, 1, 0);
    for (int k = 1; k <= 16; k++) cycle(0, 0, 0, 1, 1);
    chk_all("ia16", 3, 1, 0, 2, 0, 16, 0, 0);
    cycle(0, 0, 0, 1, 1);
    chk_all("iawin", 0, 0, 0, 2, 0, 17, 1, 1);

`ifdef TURN_TIMEOUT_EN
    cycle(1, 0, 0, 0, 0);
    place_all_ships();
    for (int k = 1; k <= 7; k++) cycle(0, 0, 0, 0, 0);
    chk("to_pre.turn", int'(turn), 2);
    cycle(0, 0, 0, 0, 0);
    chk("to_exp.turn", int'(turn), 3);
    chk("to_exp.player_hits", int'(player_hits), 0);
    cycle(0, 0, 0, 1, 0);
    chk("to_back.turn", int'(turn), 2);
    for (int k = 1; k <= 7; k++) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1); // shot lands on the expiry cycle
    chk("to_shot.turn", int'(turn), 2);
    chk("to_shot.player_hits", int'(player_hits), 1);
    for (int k = 1; k <= 7; k++) cycle(0, 0, 0, 0, 0);
    chk("to_re.turn", int'(turn), 2);
    cycle(0, 0, 0, 0, 0);
    chk("to_re_exp.turn", int'(turn), 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
